// File: rtl/spad_reader.sv
// Strided burst reader: scratchpad SRAM to a valid/ready stream through a 3-entry skid FIFO.
// SPAD_RD_WRAP_EN: addresses wrap modulo NUM_REG instead of truncating to ADDR_WIDTH bits.

// Small synchronous FIFO with a zeroed head when empty.
// Latency: push visible at the head on the next cycle.
// Backpressure: pop is ignored when empty; push is dropped when full unless a pop frees a slot.
module spad_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [W-1:0]                 push_dat,
  input  logic                         pop,
  output logic [W-1:0]                 head_dat,
  output logic                         head_vld,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head_vld = (count != '0);
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop & head_vld;
  assign do_push  = push & (~full | do_pop);
  assign head_dat = head_vld ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// Issues len strided SRAM reads per start and streams the words out in order.
// Latency: first read the cycle after start, first out_valid three cycles after start.
// Backpressure: reads are throttled so buffered plus in-flight words never exceed three.
module spad_reader #(
  parameter int NUM_REG    = 24,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  input  logic [ADDR_WIDTH-1:0] stride,
  output logic                  sram_chip_en,
  output logic                  sram_ren,
  output logic [ADDR_WIDTH-1:0] sram_raddr,
  input  logic [DATA_WIDTH-1:0] sram_dout,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);
  localparam int AW1 = ADDR_WIDTH + 1;
  localparam logic [AW1-1:0] NUM_REG_W = AW1'(NUM_REG);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] READ   = 2'd1;
  localparam logic [1:0] DRAIN  = 2'd2;
  localparam logic [1:0] FINISH = 2'd3;

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [ADDR_WIDTH-1:0] stride_q;
  logic [AW1-1:0]        rd_left;
  logic [AW1-1:0]        xfer_left;
  logic [AW1-1:0]        len_clip;
  logic                  inflight;
  logic [1:0]            fifo_count;
  logic [2:0]            occ_sum;
  logic [2:0]            occ_limit;
  logic                  xfer;
  logic                  issue;
  logic                  accept;

`ifdef SPAD_RD_WRAP_EN
  logic [AW1-1:0] addr_sum;
  assign addr_sum = {1'b0, addr} + {1'b0, stride_q};
  assign addr_nxt = ADDR_WIDTH'(addr_sum % NUM_REG_W);
`else
  assign addr_nxt = addr + stride_q;
`endif

  // Out-of-range lengths are clipped to the scratchpad size.
  assign len_clip  = (len > NUM_REG_W) ? NUM_REG_W : len;
  assign accept    = (state == IDLE) & start;
  assign xfer      = out_valid & out_ready;
  assign occ_sum   = {1'b0, fifo_count} + {2'b00, inflight};
  assign occ_limit = 3'd3 + {2'b00, xfer};
  assign issue     = (state == READ) && (rd_left != '0) && (occ_sum < occ_limit);

  assign sram_ren     = issue;
  assign sram_chip_en = issue;
  assign sram_raddr   = addr;
  assign busy         = (state != IDLE);
  assign done         = (state == FINISH);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (len_clip == '0) ? FINISH : READ;
      READ:    if (issue && rd_left == AW1'(1)) state_nxt = DRAIN;
      DRAIN:   if (xfer && xfer_left == AW1'(1)) state_nxt = FINISH;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      stride_q  <= '0;
      rd_left   <= '0;
      xfer_left <= '0;
      inflight  <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= issue;
      if (accept) begin
        addr      <= base_addr;
        stride_q  <= stride;
        rd_left   <= len_clip;
        xfer_left <= len_clip;
      end else begin
        if (issue) begin
          addr    <= addr_nxt;
          rd_left <= rd_left - 1'b1;
        end
        if (xfer) xfer_left <= xfer_left - 1'b1;
      end
    end
  end

  // Read data lands one cycle after the read and is pushed at the end of that cycle.
  spad_fifo #(
    .W     (DATA_WIDTH),
    .DEPTH (3)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (inflight),
    .push_dat (sram_dout),
    .pop      (out_ready),
    .head_dat (out_data),
    .head_vld (out_valid),
    .count    (fifo_count)
  );
endmodule

// File: tb/tb_spad_reader.sv
// Randomized bench for spad_reader against an address/data list model and an SRAM array.
module tb_spad_reader;
  localparam int NR = 24;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  base_addr;
  logic [5:0]  len;
  logic [4:0]  stride;
  logic        sram_chip_en;
  logic        sram_ren;
  logic [4:0]  sram_raddr;
  logic [15:0] sram_dout;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;

  logic [15:0] tb_mem [32];
  int n_tests = 0;
  int n_fail  = 0;

  spad_reader #(.NUM_REG(NR), .DATA_WIDTH(16), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .stride(stride), .sram_chip_en(sram_chip_en), .sram_ren(sram_ren),
    .sram_raddr(sram_raddr), .sram_dout(sram_dout), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sram_ren) sram_dout <= tb_mem[sram_raddr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int addr_model(input int b, input int s, input int k);
`ifdef SPAD_RD_WRAP_EN
    return (k == 0) ? b : (b + k * s) % NR;
`else
    return (b + k * s) % 32;
`endif
  endfunction

  function automatic logic rdy_pat(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (cyc % 4 == 0) || (cyc % 4 == 3);
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_chip_en"}, sram_chip_en, 0);
    chk({tag, "_ren"},     sram_ren, 0);
    chk({tag, "_raddr"},   sram_raddr, 0);
    chk({tag, "_valid"},   out_valid, 0);
    chk({tag, "_data"},    out_data, 0);
    chk({tag, "_busy"},    busy, 0);
    chk({tag, "_done"},    done, 0);
  endtask

  // mode: 0 ready high, 1 ready pattern 1,0,0,1, 2 random ready
  task automatic burst(input int b, input int l, input int s, input int mode, input bit inject);
    int          exp_addr[$];
    logic [15:0] exp_dat[$];
    int          nrd, nxf, cyc, first_vld, done_cyc, a;
    bit          prev_stall, seen_done;
    logic [15:0] prev_dat;
    for (int k = 0; k < l; k++) begin
      a = addr_model(b, s, k);
      exp_addr.push_back(a);
      exp_dat.push_back(tb_mem[a]);
    end
    nrd = 0; nxf = 0; cyc = 0; first_vld = -1; done_cyc = -1;
    prev_stall = 0; seen_done = 0; prev_dat = '0;
    @(posedge clk); #1;
    start = 1'b1; base_addr = b[4:0]; len = l[5:0]; stride = s[4:0];
    out_ready = rdy_pat(mode, 0);
    forever begin
      @(negedge clk);
      chk("busy", busy, (cyc > 0));
      if (sram_ren || sram_chip_en) chk("chip_en_eq_ren", {sram_chip_en, sram_ren}, 2'b11);
      if (sram_ren) begin
        if (nrd < l) chk("raddr", sram_raddr, exp_addr[nrd]);
        else         chk("extra_read", nrd, l);
        nrd++;
      end
      if (out_valid && first_vld < 0) first_vld = cyc;
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, prev_dat);
      end
      if (out_valid && out_ready) begin
        if (nxf < l) chk("data", out_data, exp_dat[nxf]);
        else         chk("extra_xfer", nxf, l);
        nxf++;
      end
      chk("outstanding_le3", (nrd - nxf) <= 3, 1);
      prev_stall = out_valid && !out_ready;
      prev_dat   = out_data;
      if (done) begin
        seen_done = 1;
        done_cyc  = cyc;
        break;
      end
      if (cyc >= 400) break;
      @(posedge clk); #1;
      cyc++;
      start = inject && (cyc == 2 || cyc == 5);
      if (start) begin
        base_addr = 5'($urandom_range(0, 31));
        len       = 6'($urandom_range(0, 24));
        stride    = 5'($urandom_range(0, 31));
      end
      out_ready = rdy_pat(mode, cyc);
    end
    chk("done_seen", seen_done, 1);
    chk("n_reads", nrd, l);
    chk("n_xfers", nxf, l);
    if (mode == 0) begin
      chk("done_cycle", done_cyc, (l == 0) ? 1 : l + 3);
      if (l > 0) chk("first_valid_cycle", first_vld, 3);
    end
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) tb_mem[i] = 16'($urandom);
    rst = 1'b1; start = 1'b0; base_addr = '0; len = '0; stride = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");

    burst(0, 4, 1, 0, 0);
    burst(20, 6, 2, 0, 0);
    burst(0, 8, 3, 1, 0);
    burst(5, 0, 1, 0, 0);
    burst(23, 24, 5, 2, 0);
    burst(9, 24, 0, 0, 0);

    // Reset two cycles into the read phase of a long burst.
    @(posedge clk); #1;
    start = 1'b1; base_addr = 5'd4; len = 6'd10; stride = 5'd1; out_ready = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("midburst_rst");
    burst(3, 2, 1, 0, 0);

    // Reset wins over a simultaneous start.
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b1; base_addr = 5'd1; len = 6'd3; stride = 5'd1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rst_over_start_busy", busy, 0);
    chk("rst_over_start_ren", sram_ren, 0);

    burst(2, 8, 1, 2, 1);
    burst(17, 8, 7, 1, 1);

    for (int t = 0; t < 20; t++) begin
      burst($urandom_range(0, NR - 1), $urandom_range(0, NR), $urandom_range(0, 31),
            $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
